// File: rtl/muldiv_seq.sv
// muldiv_seq: multi-cycle RV32M multiply/divide/remainder sequencer.
//
// It uses radix-2 shift-add multiplication and restoring division. Each
// iteration issues one add or subtract on the core's shared adder. The
// microcode arbiter grants that adder for the whole time busy_o is high.
//
// Ports
//   clk_i, rst_i       clock, synchronous active-high reset
//   req_valid_i        operation request from the microcode engine
//   req_ready_o        sequencer can accept a request (IDLE only)
//   req_op_i           0 MUL, 1 MULH, 2 MULHSU, 3 MULHU,
//                      4 DIV, 5 DIVU, 6 REM, 7 REMU
//   req_a_i, req_b_i   rs1 / rs2 operands
//   kill_i             abort the in-flight operation, no response
//   resp_valid_o       result available (held until resp_ready_i)
//   resp_ready_i       consumer accepts the result
//   resp_data_o        result word
//   busy_o             high outside IDLE, adder grant must be held
//   adder_op_o         0 = ADDER_ADD, 1 = ADDER_SUB
//   adder_a_o/b_o      shared adder sources
//   adder_out_i        combinational adder result, same cycle
//   adder_cout_i       ADD: carry out; SUB: 1 iff a < b unsigned
module muldiv_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [2:0]       req_op_i,
    input  logic [WIDTH-1:0] req_a_i,
    input  logic [WIDTH-1:0] req_b_i,
    input  logic             kill_i,
    output logic             resp_valid_o,
    input  logic             resp_ready_i,
    output logic [WIDTH-1:0] resp_data_o,
    output logic             busy_o,
    output logic             adder_op_o,
    output logic [WIDTH-1:0] adder_a_o,
    output logic [WIDTH-1:0] adder_b_o,
    input  logic [WIDTH-1:0] adder_out_i,
    input  logic             adder_cout_i
);

    localparam logic ADDER_ADD = 1'b0;
    localparam logic ADDER_SUB = 1'b1;

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_DIVU   = 3'd5;
    localparam logic [2:0] OP_REM    = 3'd6;
    localparam logic [2:0] OP_REMU   = 3'd7;

    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {
        IDLE,
        PREP,
        ITER,
        FIX,
        DONE
    } state_t;

    state_t               state_q, state_d;
    logic [2:0]           op_q, op_d;
    // hi: multiply accumulator high word / division partial remainder
    logic [WIDTH-1:0]     hi_q, hi_d;
    // lo: raw a, then multiplier (shifted right) / quotient (shifted in)
    logic [WIDTH-1:0]     lo_q, lo_d;
    // dvs: raw b, then multiplicand / divisor magnitude
    logic [WIDTH-1:0]     dvs_q, dvs_d;
    logic                 sign_q, sign_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]     respData_q, respData_d;

    logic                 isDiv;
    logic                 aSigned;
    logic                 bSigned;
    logic                 aNeg;
    logic                 bNeg;
    logic [WIDTH-1:0]     shRem;
    logic                 qBit;
    logic [2*WIDTH-1:0]   product;
    logic [2*WIDTH-1:0]   productNeg;
    logic [2*WIDTH-1:0]   productSel;
    logic [WIDTH-1:0]     divSel;
    logic                 reqDivByZero;
    logic                 reqOverflow;
    logic                 reqSpecial;
    logic [WIDTH-1:0]     reqSpecialRes;

    // Operand signedness and sign detection for the captured operation.
    assign isDiv   = op_q[2];
    assign aSigned = (op_q == OP_MULH) || (op_q == OP_MULHSU) ||
                     (op_q == OP_DIV)  || (op_q == OP_REM);
    assign bSigned = (op_q == OP_MULH) || (op_q == OP_DIV) || (op_q == OP_REM);
    assign aNeg    = aSigned && lo_q[WIDTH-1];
    assign bNeg    = bSigned && dvs_q[WIDTH-1];

    // Restoring division step: the bit shifted out of the remainder makes the
    // trial subtraction succeed even when the WIDTH-bit compare says a < b.
    assign shRem = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
    assign qBit  = hi_q[WIDTH-1] | ~adder_cout_i;

    // The full double-width product is negated so the low-word borrow carries
    // into the high word.
    assign product    = {hi_q, lo_q};
    assign productNeg = -product;
    assign productSel = sign_q ? productNeg : product;
    assign divSel     = op_q[1] ? hi_q : lo_q;

    // Requests that resolve without iterating.
    assign reqDivByZero  = req_op_i[2] && (req_b_i == '0);
    assign reqOverflow   = ((req_op_i == OP_DIV) || (req_op_i == OP_REM)) &&
                           (req_a_i == MIN_NEG) && (req_b_i == '1);
    assign reqSpecial    = reqDivByZero || reqOverflow;
    assign reqSpecialRes = reqDivByZero ? (req_op_i[1] ? req_a_i : '1)
                                        : (req_op_i[1] ? '0 : MIN_NEG);

    // State register and datapath registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            op_q       <= OP_MUL;
            hi_q       <= '0;
            lo_q       <= '0;
            dvs_q      <= '0;
            sign_q     <= 1'b0;
            cnt_q      <= '0;
            respData_q <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            dvs_q      <= dvs_d;
            sign_q     <= sign_d;
            cnt_q      <= cnt_d;
            respData_q <= respData_d;
        end
    end

    // Next-state, datapath and adder drive. The adder is held at ADD/0/0
    // outside ITER so the shared unit does not toggle needlessly.
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        dvs_d      = dvs_q;
        sign_d     = sign_q;
        cnt_d      = cnt_q;
        respData_d = respData_q;
        adder_op_o = ADDER_ADD;
        adder_a_o  = '0;
        adder_b_o  = '0;

        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    op_d  = req_op_i;
                    lo_d  = req_a_i;
                    dvs_d = req_b_i;
                    if (reqSpecial) begin
                        respData_d = reqSpecialRes;
                        state_d    = DONE;
                    end else begin
                        state_d = PREP;
                    end
                end
            end

            PREP: begin
                lo_d   = aNeg ? -lo_q : lo_q;
                dvs_d  = bNeg ? -dvs_q : dvs_q;
                sign_d = (op_q == OP_REM) ? aNeg : (aNeg ^ bNeg);
                hi_d   = '0;
                cnt_d  = CNT_W'(WIDTH);
                state_d = ITER;
            end

            ITER: begin
                if (isDiv) begin
                    adder_op_o = ADDER_SUB;
                    adder_a_o  = shRem;
                    adder_b_o  = dvs_q;
                    hi_d       = qBit ? adder_out_i : shRem;
                    lo_d       = {lo_q[WIDTH-2:0], qBit};
                end else begin
                    adder_op_o   = ADDER_ADD;
                    adder_a_o    = hi_q;
                    adder_b_o    = lo_q[0] ? dvs_q : '0;
                    {hi_d, lo_d} = {adder_cout_i, adder_out_i, lo_q[WIDTH-1:1]};
                end
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = FIX;
                end
            end

            FIX: begin
                case (op_q)
                    OP_MUL:                      respData_d = productSel[WIDTH-1:0];
                    OP_MULH, OP_MULHSU, OP_MULHU: respData_d = productSel[2*WIDTH-1:WIDTH];
                    OP_DIV, OP_REM:              respData_d = sign_q ? -divSel : divSel;
                    default:                     respData_d = divSel;
                endcase
                state_d = DONE;
            end

            DONE: begin
                if (resp_ready_i) begin
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase

        // An abort outranks every other transition, including result handoff.
        if (kill_i && (state_q != IDLE)) begin
            state_d = IDLE;
        end
    end

    assign req_ready_o  = (state_q == IDLE);
    assign busy_o       = (state_q != IDLE);
    assign resp_valid_o = (state_q == DONE);
    assign resp_data_o  = respData_q;

endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
- Multi-cycle sequencer for RV32M multiply/divide/remainder on the core's shared 32-bit adder.
- Uses radix-2 shift-add multiplication and restoring division. Drives the adder for one add or subtract per iteration.
- Sits between the microcode engine (request/response handshake) and the shared adder port. The microcode arbiter gives it the adder for the whole time it is busy.

Parameters:
- WIDTH, 32, operand/result width; also the shared adder width.
- CNT_W, $clog2(WIDTH)+1, width of the iteration counter.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  operation request
- req_ready  out  1  sequencer can accept a request (IDLE only)
- req_op  in  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- req_a  in  WIDTH  rs1 operand
- req_b  in  WIDTH  rs2 operand
- kill  in  1  abort the in-flight op; no response is produced
- resp_valid  out  1  result available
- resp_ready  in  1  consumer accepts result
- resp_data  out  WIDTH  result
- busy  out  1  high outside IDLE; adder grant must be held
- adder_op  out  adderOp_t  ADDER_ADD or ADDER_SUB only
- adder_a  out  WIDTH  adder source a
- adder_b  out  WIDTH  adder source b
- adder_out  in  WIDTH  combinational sum/difference, same cycle
- adder_cout  in  1  ADD: carry out; SUB: 1 iff adder_a < adder_b unsigned

Behaviour:
- Reset values: req_ready=1, resp_valid=0, resp_data=0, busy=0, adder_op=ADDER_ADD, adder_a=0, adder_b=0, counter=0. rst mid-operation returns to IDLE next cycle and drops any pending result.
- States: IDLE, PREP, ITER, FIX, DONE.
- IDLE:
  - On req_valid & req_ready, capture op/a/b and go to PREP.
  - Special cases go straight to DONE with the result loaded:
    - div/rem with b==0: DIV/DIVU give all-ones; REM/REMU give a.
    - DIV/REM with a==0x8000_0000 and b==all-ones: DIV gives 0x8000_0000, REM gives 0.
- PREP (1 cycle):
  - Take magnitudes of signed operands with local negation logic, not the adder.
  - Signed: MULH both operands, MULHSU a only, DIV/REM both.
  - Record the result sign:
    - MUL/MULH/MULHSU and DIV: sign(a) XOR sign(b), per the signedness above.
    - REM: sign(a).
  - Clear the accumulator; counter=WIDTH; go to ITER.
- ITER (exactly WIDTH cycles), multiply:
  - adder_op=ADD, adder_a=acc_hi, adder_b = mcand if mplier[0] else 0.
  - {acc_hi, mplier} <= {adder_cout, adder_out, mplier[WIDTH-1:1]}.
- ITER, divide:
  - Shift {rem, quo} left by 1; msb = bit shifted out of rem.
  - adder_op=SUB, adder_a=shifted rem, adder_b=divisor.
  - q = msb | ~adder_cout. If q, rem <= adder_out, else rem <= shifted rem; quo[0] <= q.
- ITER ends when the counter reaches 0; go to FIX.
- FIX (1 cycle):
  - Select the result: MUL takes the low word, MULH* the high word, DIV* the quotient, REM* the remainder.
  - For multiply with result sign 1, negate the full 2*WIDTH product before selecting. The low-word borrow must propagate into the high word.
  - For DIV/REM, negate the selected word if the result sign is 1.
  - Go to DONE.
- DONE: resp_valid=1 and resp_data held stable until resp_ready; on resp_valid & resp_ready go to IDLE.
- req_ready is combinationally low outside IDLE; no back-to-back accept in the handoff cycle.
- Latency, accept to resp_valid:
  - Normal op: 1+WIDTH+1+1 = 35 cycles for WIDTH=32.
  - Special case: 1 cycle.
- kill: in any non-IDLE state, go to IDLE next cycle with resp_valid=0. kill in IDLE is ignored. If kill and resp_ready are both high in DONE, kill wins and the result is discarded.
- Adder outputs are don't-care in IDLE/PREP/FIX/DONE but driven to ADD/0/0 so the shared adder stays quiet.
- busy = (state != IDLE).

Test Plan:
- MUL a=7, b=6 → resp_data=42, resp_valid exactly 35 cycles after accept; MULHU a=0xFFFF_FFFF, b=0xFFFF_FFFF → 0xFFFF_FFFE.
- MULH a=0xFFFF_FFFF (-1), b=2 → 0xFFFF_FFFF. MULHSU a=0xFFFF_FFFF, b=0xFFFF_FFFF → 0xFFFF_FFFF. MUL a=-3, b=5 → 0xFFFF_FFF1.
- DIV a=-7, b=2 → 0xFFFF_FFFD; REM a=-7, b=2 → 0xFFFF_FFFF; DIVU a=0x8000_0000, b=3 → 0x2AAA_AAAA; REMU → 2.
- DIVU a=5, b=0 → 0xFFFF_FFFF; REM a=5, b=0 → 5; DIV a=0x8000_0000, b=-1 → 0x8000_0000; each with resp_valid 1 cycle after accept.
- Hold resp_ready=0 for 10 cycles in DONE → resp_data stable, req_ready=0. Then kill at ITER cycle 10 of a fresh op → IDLE next cycle, no resp_valid, next request correct.
- Assert rst mid-ITER → next cycle all outputs at reset values. MUL 3×4 issued after that → 12.
